dmem_initiator: RTL and testbench
=================================

Name: dmem_initiator

Overview:
- Initiator side of the data-memory request/response interface. Sits between the CPU memory stage and the dual-ported memory's dmem port.
- Accepts one load or store from the CPU and issues aligned word requests to memory.
- Handles byte and halfword accesses: read lanes are extracted with sign or zero extension, and sub-word stores use a read-modify-write sequence (Read, merge, Write).
- Returns read data plus a one-cycle done or error pulse.

Parameters:
- TIMEOUT_CYCLES, 256: response-wait limit; used only when the optional feature is compiled in.

Ports:
- clock  in  1  sole clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- cpu_valid  in  1  CPU presents an access
- cpu_ready  out  1  high only in IDLE; the access is accepted on cpu_valid&&cpu_ready
- cpu_address  in  32  byte address
- cpu_writedata  in  32  store data, taken from the low-order lanes
- cpu_memread  in  1  load
- cpu_memwrite  in  1  store
- cpu_maskmode  in  2  0=byte, 1=half, 2=word, 3=illegal
- cpu_sext  in  1  sign-extend loads
- cpu_readdata  out  32  load result; holds its value until the next load completes
- cpu_done  out  1  one-cycle completion pulse
- cpu_error  out  1  one-cycle pulse, coincident with cpu_done
- io_dmem_request_ready  in  1  memory can accept a request
- io_dmem_request_valid  out  1  request valid
- io_dmem_request_bits_address  out  32  word-aligned address, low 2 bits always 0
- io_dmem_request_bits_writedata  out  32  full word to write
- io_dmem_request_bits_operation  out  2  0=Read, 1=Write; 2 is never driven
- io_dmem_response_valid  in  1  read response valid
- io_dmem_response_bits_data  in  32  full aligned word

Behaviour:
- Reset: state=IDLE; all outputs 0 except cpu_ready=1 (cpu_ready is combinational from state); latched request fields cleared.
- Reset asserted mid-operation: the transaction is abandoned and no done pulse is produced. A late response arriving in IDLE is ignored.
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, FINISH.
- IDLE, on accept: latch address, writedata, mode and sext; off = address[1:0].
  - Error if any of: memread==memwrite; mode==3; half with off[0]=1; word with off!=0. Go to FINISH with error set; no memory request is issued.
  - Load, or sub-word store: go to RD_REQ.
  - Word store: go to WR_REQ with writedata unchanged.
- RD_REQ: drive valid=1, operation=Read, address={addr[31:2],2'b00}. Hold all request fields stable until the request fires (valid&&ready), then go to RD_WAIT.
- RD_WAIT: wait for response_valid.
  - Load: extract the lane at off (byte: data[8*off+:8]; half: data[8*off+:16]; word: the full word). Extend by sext, write cpu_readdata, go to FINISH.
  - Store: merged = response data with the byte or half lane at off replaced by the low bits of writedata. Go to WR_REQ.
- WR_REQ: drive valid=1, operation=Write, with the merged or full word. Go to FINISH when the request fires. Writes produce no response.
- FINISH: cpu_done=1 (cpu_error per the latched flag) for exactly one cycle, then return to IDLE.
- Minimum latencies from accept to done:
  - word store: 2 cycles
  - load: 3 cycles, plus the response wait
  - sub-word store: 4 cycles, plus the response wait
- An unexpected response_valid in any state other than RD_WAIT is ignored.

Optional Feature:
- Macro: DMEM_INITIATOR_TIMEOUT_EN.
- With the macro: a counter of clog2(TIMEOUT_CYCLES+1) bits is cleared on entry to RD_WAIT and increments each RD_WAIT cycle.
  - If it reaches TIMEOUT_CYCLES without a response: go to FINISH with error=1, leaving cpu_readdata and memory unwritten.
  - For a sub-word store, the write phase is skipped.
- Without the macro: RD_WAIT waits indefinitely; no counter logic is present.

Decomposition:
- Shared package dmem_pkg:
  - mem_op_e enum: READ=0, WRITE=1, READWRITE=2
  - mask_mode_e enum: BYTE, HALF, WORD
  - state enum
  - WORD_W=32 constant
- One sub-module, dmem_lane_align (combinational): performs the lane extract/extend and the merge functions. It is verified stand-alone.

Test Plan:
- Load, word: addr 0x100; memory returns 0xDEADBEEF after 2 wait cycles -> request addr 0x100 op 0; cpu_readdata=0xDEADBEEF; a single cpu_done pulse.
- Load, byte, sext: addr 0x103; response 0x80FF_0000 -> cpu_readdata=0xFFFFFF80. Same access with sext=0 -> 0x00000080.
- Store, half: addr 0x202, writedata 0x1234, old word 0xAABBCCDD -> Read at 0x200, then Write at 0x200 with data 0x1234CCDD; done 1 cycle after the write fires.
- Backpressure: request_ready held low for 5 cycles during a word store of 0xCAFEF00D -> valid, address and data stay stable throughout; exactly one request fires.
- Misaligned: half store at 0x301 -> no request_valid; cpu_done=cpu_error=1 for one cycle 1 cycle after accept.
- Reset asserted in RD_WAIT, response arriving the next cycle -> no done pulse; cpu_ready=1; cpu_readdata=0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory initiator.
package dmem_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned OFF_W  = 2;

  // Operation encoding on the dmem request channel
  typedef enum logic [1:0] {
    READ      = 2'd0,
    WRITE     = 2'd1,
    READWRITE = 2'd2
  } mem_op_e;

  // CPU access width; encoding 3 is illegal and never stored
  typedef enum logic [1:0] {
    BYTE = 2'd0,
    HALF = 2'd1,
    WORD = 2'd2
  } mask_mode_e;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR_REQ  = 3'd3,
    FINISH  = 3'd4
  } state_e;

  // Request payload presented to the memory port
  typedef struct packed {
    logic [WORD_W-1:0] address;
    logic [WORD_W-1:0] writedata;
    mem_op_e           operation;
  } dmem_req_t;

  // Clear the byte offset so every request addresses a whole word
  function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] addr);
    return {addr[WORD_W-1:OFF_W], OFF_W'(0)};
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte/halfword lane handling: load extract+extend, and store merge into an old word.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [WORD_W-1:0] rdata,
  input  logic [OFF_W-1:0]  off,
  input  mask_mode_e        mode,
  input  logic              sext,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] load_data,
  output logic [WORD_W-1:0] merge_data
);

  logic [4:0]        shamt;
  logic [WORD_W-1:0] lane_mask;
  logic [WORD_W-1:0] shifted;
  logic              sign;

  // Shift the addressed lane to bit 0 for loads; shift the store lane up for merges
  always_comb begin
    shamt     = {off, 3'b000};
    shifted   = rdata >> shamt;
    lane_mask = '1;
    sign      = 1'b0;
    case (mode)
      BYTE: begin
        lane_mask = WORD_W'(32'h0000_00ff);
        sign      = sext & shifted[7];
      end
      HALF: begin
        lane_mask = WORD_W'(32'h0000_ffff);
        sign      = sext & shifted[15];
      end
      default: begin
        lane_mask = '1;
        sign      = 1'b0;
      end
    endcase
    load_data  = (shifted & lane_mask) | ({WORD_W{sign}} & ~lane_mask);
    merge_data = (rdata & ~(lane_mask << shamt)) | ((wdata & lane_mask) << shamt);
  end

endmodule

// File: rtl/dmem_initiator.sv
// CPU-side initiator for the dmem port: aligned word requests, sub-word
// loads via lane extract, sub-word stores via read-modify-write.
// Optional: define DMEM_INITIATOR_TIMEOUT_EN to bound the response wait.
module dmem_initiator
  import dmem_pkg::*;
`ifdef DMEM_INITIATOR_TIMEOUT_EN
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
)
`endif
(
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_valid,
  output logic              cpu_ready,
  input  logic [WORD_W-1:0] cpu_address,
  input  logic [WORD_W-1:0] cpu_writedata,
  input  logic              cpu_memread,
  input  logic              cpu_memwrite,
  input  logic [1:0]        cpu_maskmode,
  input  logic              cpu_sext,
  output logic [WORD_W-1:0] cpu_readdata,
  output logic              cpu_done,
  output logic              cpu_error,
  input  logic              io_dmem_request_ready,
  output logic              io_dmem_request_valid,
  output logic [WORD_W-1:0] io_dmem_request_bits_address,
  output logic [WORD_W-1:0] io_dmem_request_bits_writedata,
  output logic [1:0]        io_dmem_request_bits_operation,
  input  logic              io_dmem_response_valid,
  input  logic [WORD_W-1:0] io_dmem_response_bits_data
);

  state_e            state_q;
  state_e            state_d;
  logic [WORD_W-1:0] addr_q;
  logic [WORD_W-1:0] wword_q;
  mask_mode_e        mode_q;
  logic              sext_q;
  logic              load_q;
  logic              err_q;
  logic [WORD_W-1:0] rdata_q;

  logic [OFF_W-1:0]  acc_off;
  logic              acc_err;
  logic              acc_word_st;
  logic              req_fire;
  logic              tmo_hit;
  dmem_req_t         req;
  logic [WORD_W-1:0] lane_load;
  logic [WORD_W-1:0] lane_merge;

  // wword_q holds the raw store data until the merge replaces it with the full word
  dmem_lane_align u_lane_align (
    .rdata      (io_dmem_response_bits_data),
    .off        (addr_q[OFF_W-1:0]),
    .mode       (mode_q),
    .sext       (sext_q),
    .wdata      (wword_q),
    .load_data  (lane_load),
    .merge_data (lane_merge)
  );

  // Classify the access being offered by the CPU
  always_comb begin
    acc_off     = cpu_address[OFF_W-1:0];
    acc_err     = (cpu_memread == cpu_memwrite)
               || (cpu_maskmode == 2'd3)
               || ((cpu_maskmode == 2'(HALF)) && acc_off[0])
               || ((cpu_maskmode == 2'(WORD)) && (acc_off != OFF_W'(0)));
    acc_word_st = cpu_memwrite && (cpu_maskmode == 2'(WORD));
  end

  assign req_fire = io_dmem_request_valid && io_dmem_request_ready;

`ifdef DMEM_INITIATOR_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] tmo_cnt_q;

  // Count cycles spent waiting for a read response; zero outside RD_WAIT
  always_ff @(posedge clock) begin
    if (reset || (state_q != RD_WAIT)) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);
    end
  end

  assign tmo_hit = (state_q == RD_WAIT) && (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES));
`else
  assign tmo_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (cpu_valid) begin
          if (acc_err)          state_d = FINISH;
          else if (acc_word_st) state_d = WR_REQ;
          else                  state_d = RD_REQ;
        end
      end
      RD_REQ: begin
        if (req_fire) state_d = RD_WAIT;
      end
      RD_WAIT: begin
        if (io_dmem_response_valid) state_d = load_q ? FINISH : WR_REQ;
        else if (tmo_hit)           state_d = FINISH;
      end
      WR_REQ: begin
        if (req_fire) state_d = FINISH;
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Latch the access on accept; capture load result or merged store word on response
  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q  <= '0;
      wword_q <= '0;
      mode_q  <= BYTE;
      sext_q  <= 1'b0;
      load_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cpu_valid) begin
            addr_q  <= cpu_address;
            wword_q <= cpu_writedata;
            mode_q  <= (cpu_maskmode == 2'd3) ? WORD : mask_mode_e'(cpu_maskmode);
            sext_q  <= cpu_sext;
            load_q  <= cpu_memread;
            err_q   <= acc_err;
          end
        end
        RD_WAIT: begin
          if (io_dmem_response_valid) begin
            if (load_q) rdata_q <= lane_load;
            else        wword_q <= lane_merge;
          end else if (tmo_hit) begin
            err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Moore outputs decoded from the current state
  always_comb begin
    cpu_ready             = 1'b0;
    cpu_done              = 1'b0;
    cpu_error             = 1'b0;
    io_dmem_request_valid = 1'b0;
    req.address           = word_align(addr_q);
    req.writedata         = wword_q;
    req.operation         = READ;
    case (state_q)
      IDLE:   cpu_ready = 1'b1;
      RD_REQ: io_dmem_request_valid = 1'b1;
      WR_REQ: begin
        io_dmem_request_valid = 1'b1;
        req.operation         = WRITE;
      end
      FINISH: begin
        cpu_done  = 1'b1;
        cpu_error = err_q;
      end
      default: ;
    endcase
  end

  assign io_dmem_request_bits_address   = req.address;
  assign io_dmem_request_bits_writedata = req.writedata;
  assign io_dmem_request_bits_operation = req.operation;
  assign cpu_readdata                   = rdata_q;

endmodule

// File: tb/tb_dmem_initiator.sv
// Scoreboard bench for dmem_initiator with a behavioural memory responder.
module tb_dmem_initiator;

  logic        clock;
  logic        reset;
  logic        cpu_valid;
  logic        cpu_ready;
  logic [31:0] cpu_address;
  logic [31:0] cpu_writedata;
  logic        cpu_memread;
  logic        cpu_memwrite;
  logic [1:0]  cpu_maskmode;
  logic        cpu_sext;
  logic [31:0] cpu_readdata;
  logic        cpu_done;
  logic        cpu_error;
  logic        io_dmem_request_ready;
  logic        io_dmem_request_valid;
  logic [31:0] io_dmem_request_bits_address;
  logic [31:0] io_dmem_request_bits_writedata;
  logic [1:0]  io_dmem_request_bits_operation;
  logic        io_dmem_response_valid;
  logic [31:0] io_dmem_response_bits_data;

  dmem_initiator dut (
    .clock                          (clock),
    .reset                          (reset),
    .cpu_valid                      (cpu_valid),
    .cpu_ready                      (cpu_ready),
    .cpu_address                    (cpu_address),
    .cpu_writedata                  (cpu_writedata),
    .cpu_memread                    (cpu_memread),
    .cpu_memwrite                   (cpu_memwrite),
    .cpu_maskmode                   (cpu_maskmode),
    .cpu_sext                       (cpu_sext),
    .cpu_readdata                   (cpu_readdata),
    .cpu_done                       (cpu_done),
    .cpu_error                      (cpu_error),
    .io_dmem_request_ready          (io_dmem_request_ready),
    .io_dmem_request_valid          (io_dmem_request_valid),
    .io_dmem_request_bits_address   (io_dmem_request_bits_address),
    .io_dmem_request_bits_writedata (io_dmem_request_bits_writedata),
    .io_dmem_request_bits_operation (io_dmem_request_bits_operation),
    .io_dmem_response_valid         (io_dmem_response_valid),
    .io_dmem_response_bits_data     (io_dmem_response_bits_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  int          n_checks;
  int          n_fail;
  int          cyc;
  int          accept_cyc;
  int          rsp_delay;
  int          stall_extra;
  int          n_rd_fire;
  int          n_wr_fire;
  int          n_valid_cycles;
  bit          rd_pend;
  logic [31:0] last_rdata;
  logic [31:0] mem [logic [31:0]];
  exp_t        exp_q[$];
  logic [31:0] exp_rd_q[$];
  wr_t         exp_wr_q[$];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  // Reference load: pick bytes out of the word by index
  function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] off,
                                             input logic [1:0] mode, input logic sx);
    logic [7:0]  b [4];
    logic [31:0] r;
    int          o;
    o = int'(off);
    for (int i = 0; i < 4; i++) b[i] = w[8*i +: 8];
    case (mode)
      2'd0:    r = {{24{sx & b[o][7]}}, b[o]};
      2'd1:    r = {{16{sx & b[o+1][7]}}, b[o+1], b[o]};
      default: r = w;
    endcase
    return r;
  endfunction

  // Reference merge: overwrite the addressed bytes of the old word
  function automatic logic [31:0] model_merge(input logic [31:0] w, input logic [31:0] wd,
                                              input logic [1:0] off, input logic [1:0] mode);
    logic [31:0] r;
    int          o;
    r = w;
    o = int'(off);
    r[8*o +: 8] = wd[7:0];
    if (mode == 2'd1) r[8*(o+1) +: 8] = wd[15:8];
    return r;
  endfunction

  // Memory responder: checks each fired request, answers reads after rsp_delay wait cycles
  initial begin
    int          rd_wait;
    logic [31:0] rd_data;
    logic [31:0] ea;
    wr_t         ew;
    rd_wait = 0;
    rd_data = '0;
    io_dmem_response_valid     = 1'b0;
    io_dmem_response_bits_data = '0;
    forever begin
      @(posedge clock);
      #1;
      io_dmem_response_valid = 1'b0;
      if (rd_pend) begin
        if (rd_wait == 0) begin
          io_dmem_response_valid     = 1'b1;
          io_dmem_response_bits_data = rd_data;
          rd_pend = 1'b0;
        end else begin
          rd_wait--;
        end
      end
      @(negedge clock);
      if (!reset && io_dmem_request_valid && io_dmem_request_ready) begin
        if (io_dmem_request_bits_operation == 2'd0) begin
          n_rd_fire++;
          check("rd_expected", 32'(exp_rd_q.size() != 0), 32'd1);
          if (exp_rd_q.size() != 0) begin
            ea = exp_rd_q.pop_front();
            check("rd_addr", io_dmem_request_bits_address, ea);
          end
          rd_pend = 1'b1;
          rd_wait = rsp_delay;
          rd_data = mem_rd(io_dmem_request_bits_address);
        end else begin
          n_wr_fire++;
          check("req_op", 32'(io_dmem_request_bits_operation), 32'd1);
          check("wr_expected", 32'(exp_wr_q.size() != 0), 32'd1);
          if (exp_wr_q.size() != 0) begin
            ew = exp_wr_q.pop_front();
            check("wr_addr", io_dmem_request_bits_address, ew.a);
            check("wr_data", io_dmem_request_bits_writedata, ew.d);
          end
          mem[io_dmem_request_bits_address] = io_dmem_request_bits_writedata;
        end
      end
    end
  end

  // Request stability under backpressure and word alignment
  initial begin
    bit          prev_stall;
    logic [31:0] pa;
    logic [31:0] pd;
    logic [1:0]  po;
    prev_stall = 1'b0;
    pa = '0;
    pd = '0;
    po = '0;
    forever begin
      @(negedge clock);
      if (io_dmem_request_valid) begin
        n_valid_cycles++;
        check("req_align", 32'(io_dmem_request_bits_address[1:0]), 32'd0);
        if (prev_stall) begin
          check("hold_addr", io_dmem_request_bits_address, pa);
          check("hold_data", io_dmem_request_bits_writedata, pd);
          check("hold_op", 32'(io_dmem_request_bits_operation), 32'(po));
        end
        prev_stall = !io_dmem_request_ready;
        pa = io_dmem_request_bits_address;
        pd = io_dmem_request_bits_writedata;
        po = io_dmem_request_bits_operation;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  // Completion monitor: pop the scoreboard on each done pulse
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (cpu_done) begin
        check("done_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("error", 32'(cpu_error), 32'(e.err));
          check("readdata", cpu_readdata, e.rdata);
          check("latency", 32'(cyc - accept_cyc), 32'(e.lat));
        end
      end else if (cpu_error) begin
        check("error_without_done", 32'(cpu_error), 32'd0);
      end
    end
  end

  task automatic start_access(input logic [31:0] a, input logic [31:0] wd, input logic rd,
                              input logic wr, input logic [1:0] mode, input logic sx,
                              input bit expect_done);
    logic [1:0]  off;
    logic [31:0] wa;
    logic [31:0] old;
    bit          err;
    exp_t        e;
    off = a[1:0];
    wa  = {a[31:2], 2'b00};
    err = (rd == wr) || (mode == 2'd3) || ((mode == 2'd1) && off[0]) ||
          ((mode == 2'd2) && (off != 2'd0));
    @(posedge clock);
    #1;
    cpu_valid     = 1'b1;
    cpu_address   = a;
    cpu_writedata = wd;
    cpu_memread   = rd;
    cpu_memwrite  = wr;
    cpu_maskmode  = mode;
    cpu_sext      = sx;
    @(negedge clock);
    check("accept_ready", 32'(cpu_ready), 32'd1);
    accept_cyc = cyc;
    e.err = err;
    e.lat = 1;
    if (!err) begin
      old = mem_rd(wa);
      if (rd) begin
        exp_rd_q.push_back(wa);
        last_rdata = model_load(old, off, mode, sx);
        e.lat = 3 + rsp_delay;
      end else if (mode == 2'd2) begin
        exp_wr_q.push_back('{wa, wd});
        e.lat = 2 + stall_extra;
      end else begin
        exp_rd_q.push_back(wa);
        exp_wr_q.push_back('{wa, model_merge(old, wd, off, mode)});
        e.lat = 4 + rsp_delay;
      end
    end
    e.rdata = last_rdata;
    if (expect_done) exp_q.push_back(e);
    @(posedge clock);
    #1;
    cpu_valid    = 1'b0;
    cpu_memread  = 1'b0;
    cpu_memwrite = 1'b0;
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clock);
      if (exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check("done_in_time", 32'(ok), 32'd1);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          snap_v;
    int          snap_w;
    int          snap_r;
    logic [1:0]  m;
    logic [1:0]  off;
    logic [31:0] a;
    logic [31:0] bad_addr [4];
    logic [1:0]  bad_mode [4];
    logic        bad_rd   [4];
    logic        bad_wr   [4];

    reset                 = 1'b1;
    cpu_valid             = 1'b0;
    cpu_address           = '0;
    cpu_writedata         = '0;
    cpu_memread           = 1'b0;
    cpu_memwrite          = 1'b0;
    cpu_maskmode          = 2'd0;
    cpu_sext              = 1'b0;
    io_dmem_request_ready = 1'b1;
    rsp_delay             = 0;
    stall_extra           = 0;
    last_rdata            = '0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst_ready", 32'(cpu_ready), 32'd1);
    check("rst_done", 32'(cpu_done), 32'd0);
    check("rst_error", 32'(cpu_error), 32'd0);
    check("rst_req_valid", 32'(io_dmem_request_valid), 32'd0);
    check("rst_req_addr", io_dmem_request_bits_address, 32'd0);
    check("rst_req_wdata", io_dmem_request_bits_writedata, 32'd0);
    check("rst_req_op", 32'(io_dmem_request_bits_operation), 32'd0);
    check("rst_readdata", cpu_readdata, 32'd0);

    // Word load with two wait cycles
    mem[32'h100] = 32'hDEAD_BEEF;
    rsp_delay = 2;
    start_access(32'h100, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b1);
    wait_done();
    check("ld_word_value", cpu_readdata, 32'hDEAD_BEEF);

    // Byte loads at offset 3, signed then unsigned
    mem[32'h100] = 32'h80FF_0000;
    rsp_delay = 0;
    start_access(32'h103, 32'h0, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1);
    wait_done();
    check("ld_byte_sext", cpu_readdata, 32'hFFFF_FF80);
    start_access(32'h103, 32'h0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1);
    wait_done();
    check("ld_byte_zext", cpu_readdata, 32'h0000_0080);

    // Halfword store: read-modify-write
    mem[32'h200] = 32'hAABB_CCDD;
    rsp_delay = 1;
    start_access(32'h202, 32'h0000_1234, 1'b0, 1'b1, 2'd1, 1'b0, 1'b1);
    wait_done();
    check("st_half_mem", mem_rd(32'h200), 32'h1234_CCDD);
    check("st_half_rd_hold", cpu_readdata, 32'h0000_0080);

    // Word store with five cycles of backpressure
    snap_w = n_wr_fire;
    io_dmem_request_ready = 1'b0;
    stall_extra = 5;
    start_access(32'h400, 32'hCAFE_F00D, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1);
    repeat (5) @(posedge clock);
    #1 io_dmem_request_ready = 1'b1;
    wait_done();
    stall_extra = 0;
    check("bp_one_fire", 32'(n_wr_fire - snap_w), 32'd1);
    check("bp_mem", mem_rd(32'h400), 32'hCAFE_F00D);

    // Illegal accesses: no memory traffic, error with done one cycle after accept
    bad_addr[0] = 32'h301; bad_mode[0] = 2'd1; bad_rd[0] = 1'b0; bad_wr[0] = 1'b1;
    bad_addr[1] = 32'h102; bad_mode[1] = 2'd2; bad_rd[1] = 1'b1; bad_wr[1] = 1'b0;
    bad_addr[2] = 32'h100; bad_mode[2] = 2'd3; bad_rd[2] = 1'b1; bad_wr[2] = 1'b0;
    bad_addr[3] = 32'h100; bad_mode[3] = 2'd2; bad_rd[3] = 1'b1; bad_wr[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      snap_v = n_valid_cycles;
      start_access(bad_addr[i], 32'h0000_FFFF, bad_rd[i], bad_wr[i], bad_mode[i], 1'b0, 1'b1);
      wait_done();
      check("err_no_request", 32'(n_valid_cycles - snap_v), 32'd0);
    end

    // Random legal accesses with varied response delays
    for (int i = 0; i < 16; i++) mem[32'h1000 + 32'(i * 4)] = $urandom;
    for (int i = 0; i < 24; i++) begin
      m = 2'($urandom_range(0, 2));
      case (m)
        2'd0:    off = 2'($urandom_range(0, 3));
        2'd1:    off = {1'($urandom_range(0, 1)), 1'b0};
        default: off = 2'd0;
      endcase
      a = 32'h1000 + (32'($urandom_range(0, 15)) << 2) + 32'(off);
      rsp_delay = $urandom_range(0, 3);
      if (($urandom_range(0, 1)) == 1)
        start_access(a, $urandom, 1'b1, 1'b0, m, 1'($urandom_range(0, 1)), 1'b1);
      else
        start_access(a, $urandom, 1'b0, 1'b1, m, 1'b0, 1'b1);
      wait_done();
    end

    // Reset while waiting for a read; the response lands one cycle later in IDLE
    mem[32'h500] = 32'h1357_9BDF;
    rsp_delay = 1;
    snap_r = n_rd_fire;
    start_access(32'h500, 32'h0, 1'b1, 1'b0, 2'd2, 1'b0, 1'b0);
    @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    last_rdata = '0;
    repeat (5) @(negedge clock);
    check("rst_mid_read_fired", 32'(n_rd_fire - snap_r), 32'd1);
    check("rst_mid_resp_sent", 32'(rd_pend), 32'd0);
    check("rst_mid_ready", 32'(cpu_ready), 32'd1);
    check("rst_mid_readdata", cpu_readdata, 32'd0);

    // Recovery after the abandoned transaction
    mem[32'h600] = 32'h7F00_8001;
    rsp_delay = 0;
    start_access(32'h602, 32'h0, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1);
    wait_done();
    check("recover_ld_half", cpu_readdata, 32'h0000_7F00);

    repeat (3) @(negedge clock);
    check("sb_done_empty", 32'(exp_q.size()), 32'd0);
    check("sb_rd_empty", 32'(exp_rd_q.size()), 32'd0);
    check("sb_wr_empty", 32'(exp_wr_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
